// File: rtl/z80_irq_pkg.sv
// Shared definitions for the Z180 /INT0 interrupt controller:
// register map, FSM encoding and the spurious vector nibble.
package z80_irq_pkg;

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_VEC  = 2'd2;
    localparam logic [1:0] REG_ISR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } irq_state_t;

    localparam logic [3:0] SPURIOUS_LO = 4'hF;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit encoder; index 0 is the highest priority.
// Used for both acknowledge selection and EOI targeting.
module irq_prio_enc (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       valid
);

    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/z80_irq_ctrl.sv
// Prioritised mode-2 interrupt controller sharing Z180 /INT0.
// Optional per-source level mode: define IRQ_CTRL_LEVEL_EN.
module z80_irq_ctrl
    import z80_irq_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] VEC_RESET = 8'h40
) (
    input  logic               phi,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [1:0]         reg_sel,
    input  logic [7:0]         reg_din,
    input  logic               reg_wr_tick,
    input  logic               reg_rd,
    output logic [7:0]         reg_dout,
    input  logic               inta,
    input  logic               inta_tick,
    output logic [7:0]         vec_dout,
    output logic               vec_oe,
    output logic               int_n
);

    localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

    irq_state_t state;
    logic [7:0] src_ext, sync1, sync2, sync2_d;
    logic [7:0] pending, mask, in_service, vec_base;
    logic [7:0] below, eligible, rise, ack_bit;
    logic [7:0] pend_nxt, isr_nxt, rd_data;
    logic [2:0] isr_idx, elig_idx;
    logic       isr_vld, elig_vld;
    logic       wr_pend, wr_mask, wr_vec, wr_isr, eoi, ack;
`ifdef IRQ_CTRL_LEVEL_EN
    logic [7:0] lvl_mode;
    logic       wr_lvl;
`endif

    irq_prio_enc u_isr_enc (
        .req   (in_service),
        .idx   (isr_idx),
        .valid (isr_vld)
    );

    irq_prio_enc u_elig_enc (
        .req   (eligible),
        .idx   (elig_idx),
        .valid (elig_vld)
    );

    always_comb begin
        src_ext = '0;
        src_ext[NUM_SRC-1:0] = irq_src;
    end

    // Only sources strictly above the current in-service level may nest.
    assign below    = isr_vld ? 8'((9'd1 << isr_idx) - 9'd1) : 8'hFF;
    assign eligible = pending & mask & below;
    assign rise     = sync2 & ~sync2_d;

    assign wr_pend = reg_wr_tick && (reg_sel == REG_PEND);
    assign wr_mask = reg_wr_tick && (reg_sel == REG_MASK);
    assign wr_vec  = reg_wr_tick && (reg_sel == REG_VEC);
    assign wr_isr  = reg_wr_tick && (reg_sel == REG_ISR);
`ifdef IRQ_CTRL_LEVEL_EN
    assign wr_lvl  = wr_isr && reg_din[7];
    assign eoi     = wr_isr && !reg_din[7];
`else
    assign eoi     = wr_isr;
`endif

    assign ack     = (state == REQ) && inta_tick && elig_vld;
    assign ack_bit = ack ? (8'd1 << elig_idx) : 8'd0;

    always_comb begin
        pend_nxt = pending;
        if (wr_pend)
            pend_nxt = pend_nxt & ~reg_din;
        pend_nxt = (pend_nxt & ~ack_bit) | rise;
`ifdef IRQ_CTRL_LEVEL_EN
        pend_nxt = (pend_nxt & ~lvl_mode) | (sync2 & lvl_mode);
`endif
        pend_nxt = pend_nxt & SRC_MASK;
    end

    always_comb begin
        isr_nxt = in_service;
        if (eoi && isr_vld)
            isr_nxt = isr_nxt & ~(8'd1 << isr_idx);
        isr_nxt = isr_nxt | ack_bit;
    end

    always_comb begin
        rd_data = 8'd0;
        unique case (reg_sel)
            REG_PEND: rd_data = pending;
            REG_MASK: rd_data = mask;
            REG_VEC:  rd_data = vec_base;
            REG_ISR:  rd_data = in_service;
        endcase
    end

    assign reg_dout = reg_rd ? rd_data : 8'd0;

    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            sync2_d    <= '0;
            pending    <= '0;
            mask       <= '0;
            in_service <= '0;
            vec_base   <= VEC_RESET;
        end else begin
            sync1      <= src_ext;
            sync2      <= sync1;
            sync2_d    <= sync2;
            pending    <= pend_nxt;
            in_service <= isr_nxt;
            if (wr_mask)
                mask <= reg_din & SRC_MASK;
            if (wr_vec)
                vec_base <= reg_din;
        end
    end

`ifdef IRQ_CTRL_LEVEL_EN
    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n)
            lvl_mode <= '0;
        else if (wr_lvl)
            lvl_mode <= {1'b0, reg_din[6:0]} & SRC_MASK;
    end
`endif

    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            int_n    <= 1'b1;
            vec_oe   <= 1'b0;
            vec_dout <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (inta_tick) begin
                        vec_dout <= {vec_base[7:4], SPURIOUS_LO};
                        vec_oe   <= 1'b1;
                    end else if (!inta) begin
                        vec_oe <= 1'b0;
                    end
                    if (elig_vld) begin
                        state <= REQ;
                        int_n <= 1'b0;
                    end
                end
                REQ: begin
                    if (inta_tick) begin
                        vec_oe <= 1'b1;
                        int_n  <= 1'b1;
                        if (elig_vld) begin
                            vec_dout <= {vec_base[7:4], elig_idx, 1'b0};
                            state    <= ACK;
                        end else begin
                            vec_dout <= {vec_base[7:4], SPURIOUS_LO};
                            state    <= IDLE;
                        end
                    end else begin
                        if (!inta)
                            vec_oe <= 1'b0;
                        if (!elig_vld) begin
                            state <= IDLE;
                            int_n <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (!inta) begin
                        vec_oe <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// Self-checking bench for z80_irq_ctrl: directed scenarios plus
// a randomized run against a priority/nesting reference model.
module tb_z80_irq_ctrl;
    import z80_irq_pkg::*;

    localparam int N = 4;

    logic         phi = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] irq_src = '0;
    logic [1:0]   reg_sel = '0;
    logic [7:0]   reg_din = '0;
    logic         reg_wr_tick = 1'b0;
    logic         reg_rd = 1'b0;
    logic         inta = 1'b0;
    logic         inta_tick = 1'b0;
    logic [7:0]   reg_dout, vec_dout;
    logic         vec_oe, int_n;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [N-1:0] m_pend, m_mask, m_isr;
    logic [7:0]   m_vb;

    z80_irq_ctrl #(.NUM_SRC(N), .VEC_RESET(8'h40)) dut (
        .phi         (phi),
        .reset_n     (reset_n),
        .irq_src     (irq_src),
        .reg_sel     (reg_sel),
        .reg_din     (reg_din),
        .reg_wr_tick (reg_wr_tick),
        .reg_rd      (reg_rd),
        .reg_dout    (reg_dout),
        .inta        (inta),
        .inta_tick   (inta_tick),
        .vec_dout    (vec_dout),
        .vec_oe      (vec_oe),
        .int_n       (int_n)
    );

    always #5 phi = ~phi;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Source to serve next: lowest pending&enabled index above the
    // lowest in-service index; -1 when nothing can be served.
    function automatic int model_target();
        int lim = N;
        for (int i = N - 1; i >= 0; i--)
            if (m_isr[i]) lim = i;
        for (int i = 0; i < lim; i++)
            if (m_pend[i] && m_mask[i]) return i;
        return -1;
    endfunction

    task automatic wr(input logic [1:0] s, input logic [7:0] d);
        @(negedge phi);
        reg_sel = s; reg_din = d; reg_wr_tick = 1'b1;
        @(negedge phi);
        reg_wr_tick = 1'b0;
        repeat (2) @(negedge phi);
    endtask

    task automatic rd(input logic [1:0] s, output logic [7:0] v);
        reg_sel = s; reg_rd = 1'b1;
        #1 v = reg_dout;
        reg_rd = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] bits);
        @(negedge phi);
        irq_src = bits;
        repeat (2) @(negedge phi);
        irq_src = '0;
        repeat (3) @(negedge phi);
    endtask

    task automatic do_ack(output logic [7:0] v, output logic oh,
                          output logic oa);
        @(negedge phi);
        inta = 1'b1; inta_tick = 1'b1;
        @(negedge phi);
        inta_tick = 1'b0;
        v = vec_dout; oh = vec_oe;
        @(negedge phi);
        inta = 1'b0;
        @(negedge phi);
        oa = vec_oe;
        repeat (2) @(negedge phi);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        repeat (3) @(negedge phi);
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL reset_int_n: got %b want 1", int_n); end
        checks++; if (vec_oe !== 1'b0) begin errors++; $display("FAIL reset_vec_oe: got %b want 0", vec_oe); end
        checks++; if (vec_dout !== 8'h00) begin errors++; $display("FAIL reset_vec_dout: got %h want 00", vec_dout); end
        rd(REG_PEND, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_pend: got %h want 00", v); end
        rd(REG_MASK, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h want 00", v); end
        rd(REG_VEC, v);
        checks++; if (v !== 8'h40) begin errors++; $display("FAIL reset_vec: got %h want 40", v); end
        rd(REG_ISR, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_isr: got %h want 00", v); end
        @(negedge phi);
        reset_n = 1'b1;
        repeat (2) @(negedge phi);
    endtask

    task automatic test_basic();
        logic [7:0] v;
        logic oh, oa;
        int cnt = 0;
        wr(REG_MASK, 8'h01);
        @(negedge phi);
        irq_src = 4'b0001;
        while (int_n === 1'b1 && cnt < 10) begin
            @(negedge phi);
            cnt++;
        end
        irq_src = '0;
        checks++; if (cnt < 3 || cnt > 4) begin errors++; $display("FAIL basic_latency: got %0d want 3..4", cnt); end
        repeat (3) @(negedge phi);
        do_ack(v, oh, oa);
        checks++; if (v !== 8'h40) begin errors++; $display("FAIL basic_vec: got %h want 40", v); end
        checks++; if (oh !== 1'b1) begin errors++; $display("FAIL basic_oe_hold: got %b want 1", oh); end
        checks++; if (oa !== 1'b0) begin errors++; $display("FAIL basic_oe_drop: got %b want 0", oa); end
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL basic_int_n: got %b want 1", int_n); end
        rd(REG_PEND, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL basic_pend: got %h want 00", v); end
        rd(REG_ISR, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL basic_isr: got %h want 01", v); end
        wr(REG_ISR, 8'h00);
        rd(REG_ISR, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL basic_eoi: got %h want 00", v); end
    endtask

    task automatic test_priority();
        logic [7:0] v;
        logic oh, oa;
        wr(REG_MASK, 8'h0F);
        pulse(4'b0110);
        checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL prio_int_n: got %b want 0", int_n); end
        do_ack(v, oh, oa);
        checks++; if (v !== 8'h42) begin errors++; $display("FAIL prio_vec1: got %h want 42", v); end
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL prio_blocked: got %b want 1", int_n); end
        wr(REG_ISR, 8'h00);
        checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL prio_after_eoi: got %b want 0", int_n); end
        do_ack(v, oh, oa);
        checks++; if (v !== 8'h44) begin errors++; $display("FAIL prio_vec2: got %h want 44", v); end
        wr(REG_ISR, 8'h00);
        rd(REG_ISR, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL prio_isr: got %h want 00", v); end
    endtask

    task automatic test_nesting();
        logic [7:0] v;
        logic oh, oa;
        pulse(4'b0100);
        do_ack(v, oh, oa);
        rd(REG_ISR, v);
        checks++; if (v !== 8'h04) begin errors++; $display("FAIL nest_isr4: got %h want 04", v); end
        pulse(4'b1000);
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL nest_low_blocked: got %b want 1", int_n); end
        pulse(4'b0001);
        checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL nest_high_int_n: got %b want 0", int_n); end
        do_ack(v, oh, oa);
        checks++; if (v !== 8'h40) begin errors++; $display("FAIL nest_vec: got %h want 40", v); end
        rd(REG_ISR, v);
        checks++; if (v !== 8'h05) begin errors++; $display("FAIL nest_isr5: got %h want 05", v); end
        wr(REG_ISR, 8'h00);
        rd(REG_ISR, v);
        checks++; if (v !== 8'h04) begin errors++; $display("FAIL nest_eoi: got %h want 04", v); end
        wr(REG_PEND, 8'h0F);
        wr(REG_ISR, 8'h00);
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL nest_clean: got %b want 1", int_n); end
    endtask

    task automatic test_withdraw();
        logic [7:0] v;
        logic oh, oa;
        wr(REG_MASK, 8'h02);
        pulse(4'b0010);
        checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL wd_int_n: got %b want 0", int_n); end
        wr(REG_MASK, 8'h00);
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL wd_release: got %b want 1", int_n); end
        checks++; if (vec_oe !== 1'b0) begin errors++; $display("FAIL wd_no_vec: got %b want 0", vec_oe); end
        do_ack(v, oh, oa);
        checks++; if (v !== 8'h4F) begin errors++; $display("FAIL spur_vec: got %h want 4f", v); end
        checks++; if (oh !== 1'b1 || oa !== 1'b0) begin errors++; $display("FAIL spur_oe: got %b%b want 10", oh, oa); end
        rd(REG_PEND, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL spur_pend: got %h want 02", v); end
        wr(REG_PEND, 8'hFF);
    endtask

    task automatic test_w1c_race();
        logic [7:0] v;
        @(negedge phi);
        irq_src = 4'b0010;
        repeat (2) @(negedge phi);
        reg_sel = REG_PEND; reg_din = 8'h02; reg_wr_tick = 1'b1;
        @(negedge phi);
        reg_wr_tick = 1'b0;
        irq_src = '0;
        repeat (2) @(negedge phi);
        rd(REG_PEND, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL race_set_wins: got %h want 02", v); end
        wr(REG_PEND, 8'h02);
        rd(REG_PEND, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL race_w1c: got %h want 00", v); end
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] v;
        wr(REG_VEC, 8'h80);
        wr(REG_MASK, 8'h01);
        pulse(4'b0001);
        @(negedge phi);
        inta = 1'b1; inta_tick = 1'b1;
        @(negedge phi);
        inta_tick = 1'b0;
        checks++; if (vec_oe !== 1'b1 || vec_dout !== 8'h80) begin errors++; $display("FAIL rma_ack: got %b/%h want 1/80", vec_oe, vec_dout); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (vec_oe !== 1'b0) begin errors++; $display("FAIL rma_vec_oe: got %b want 0", vec_oe); end
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL rma_int_n: got %b want 1", int_n); end
        rd(REG_VEC, v);
        checks++; if (v !== 8'h40) begin errors++; $display("FAIL rma_vec_base: got %h want 40", v); end
        rd(REG_ISR, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL rma_isr: got %h want 00", v); end
        inta = 1'b0;
        @(negedge phi);
        reset_n = 1'b1;
        repeat (2) @(negedge phi);
    endtask

    task automatic test_random();
        logic [7:0] v, d, exp;
        logic oh, oa;
        int op, tgt;
        m_pend = '0; m_mask = '0; m_isr = '0; m_vb = 8'h40;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 7);
            case (op)
                0, 1: begin
                    d = 8'($urandom_range(0, 15));
                    pulse(d[N-1:0]);
                    m_pend = m_pend | d[N-1:0];
                end
                2: begin
                    d = 8'($urandom);
                    wr(REG_MASK, d);
                    m_mask = d[N-1:0];
                    rd(REG_MASK, v);
                    checks++; if (v !== {4'h0, m_mask}) begin errors++; $display("FAIL rnd_mask_rd: got %h want %h", v, {4'h0, m_mask}); end
                end
                3: begin
                    d = 8'($urandom);
                    wr(REG_PEND, d);
                    m_pend = m_pend & ~d[N-1:0];
                end
                4, 5: begin
                    tgt = model_target();
                    do_ack(v, oh, oa);
                    if (tgt >= 0) begin
                        exp = {m_vb[7:4], 3'(tgt), 1'b0};
                        m_pend[tgt] = 1'b0;
                        m_isr[tgt] = 1'b1;
                    end else begin
                        exp = {m_vb[7:4], 4'hF};
                    end
                    checks++; if (v !== exp) begin errors++; $display("FAIL rnd_vec: got %h want %h", v, exp); end
                    checks++; if (oh !== 1'b1 || oa !== 1'b0) begin errors++; $display("FAIL rnd_oe: got %b%b want 10", oh, oa); end
                end
                6: begin
                    wr(REG_ISR, 8'h00);
                    for (int i = 0; i < N; i++)
                        if (m_isr[i]) begin
                            m_isr[i] = 1'b0;
                            break;
                        end
                end
                default: begin
                    d = 8'($urandom);
                    wr(REG_VEC, d);
                    m_vb = d;
                end
            endcase
            exp = {7'd0, model_target() < 0};
            checks++; if (int_n !== exp[0]) begin errors++; $display("FAIL rnd_int_n: got %b want %b", int_n, exp[0]); end
            rd(REG_PEND, v);
            checks++; if (v !== {4'h0, m_pend}) begin errors++; $display("FAIL rnd_pend: got %h want %h", v, {4'h0, m_pend}); end
            rd(REG_ISR, v);
            checks++; if (v !== {4'h0, m_isr}) begin errors++; $display("FAIL rnd_isr: got %h want %h", v, {4'h0, m_isr}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_nesting();
        test_withdraw();
        test_w1c_race();
        test_reset_mid_ack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
